multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Multicycle successor to the single-cycle control path: a registered FSM sequences each RV32 instruction (lw, sw, R-type, I-type ALU, beq/bne, jal) over 3–5 cycles, sharing one ALU and one unified memory.
- Adds a memory ready handshake with a bounded wait timeout, a sticky trap state for illegal opcodes or timeouts, and a retired-instruction counter.
- Sits between the instruction register/datapath and the unified memory port.

Parameters:
- WAIT_LIMIT, 15: maximum consecutive cycles a memory state may wait for mem_ready; the cycle after the limit enters TRAP. Legal range 1..255.
- BNE_EN, 1: 1 = branch opcode honours func3 001 (bne); 0 = func3 001 is illegal.
- CNT_W, 32: width of retired-instruction counter.

Ports:
- clk in 1: clock, rising edge.
- rst in 1: synchronous, active-low reset.
- Opcode in 7: instr[6:0] from the instruction register.
- func3 in 3: instr[14:12].
- func7 in 7: instr[31:25].
- Zero in 1: ALU zero flag.
- mem_ready in 1: memory completes the current access this cycle.
- PCWrite out 1: PC register enable.
- AdrSrc out 1: memory address select; 0 = PC, 1 = ALUOut.
- MemWrite out 1: memory write strobe.
- IRWrite out 1: IR and OldPC load.
- RegWrite out 1: register file write enable.
- ResultSrc out 2: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA out 2: 00 = PC, 01 = OldPC, 10 = rs1 register A.
- ALUSrcB out 2: 00 = register B, 01 = ImmExt, 10 = constant 4.
- ImmSrc out 2: 00 = I, 01 = S, 10 = B, 11 = J; decoded from Opcode in every state.
- ALUControl out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- trap out 1: high while in TRAP.
- trap_cause out 2: 01 = illegal opcode, 10 = memory timeout; 00 otherwise.
- instret out CNT_W: count of retired instructions.

Behaviour:
- State register, 4 bits. States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- Reset (rst=0 at a clock edge): state=FETCH, wait counter=0, instret=0, trap_cause=00.
- While rst=0, PCWrite, MemWrite, IRWrite and RegWrite are forced to 0.
- All other outputs are combinational from state, Opcode and func3 (ALUControl also uses func7).
- FETCH:
  - Outputs: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Goes to DECODE when mem_ready=1, else stays.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut).
  - Next state by opcode: lw (0000011) or sw (0100011) → MEMADR; R (0110011) → EXECR; I (0010011) → EXECI; branch (1100011) → BRANCH; jal (1101111) → JAL.
  - Any other opcode → TRAP with cause 01.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Goes to MEMWB on mem_ready, else stays.
- MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle in the state. Goes to FETCH on mem_ready, else stays.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp decode. Goes to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp decode. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
- BRANCH:
  - Outputs: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = (func3==000 & Zero) | (BNE_EN & func3==001 & ~Zero).
  - Any other func3 → TRAP with cause 01, and PCWrite=0.
  - Otherwise goes to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Goes to ALUWB.
- ALUOp decode (EXECR/EXECI), by func3:
  - 000: sub if Opcode[5] & func7[5], else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other func3: add; no trap.
- Wait counter:
  - Increments each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - Clears on any state change.
  - If the counter equals WAIT_LIMIT and mem_ready=0, the next state is TRAP with cause 10.
  - mem_ready=1 on the limit cycle still completes normally.
- Retirement:
  - instret increments by 1 on the transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.
  - JAL retires through ALUWB and is counted once.
  - instret wraps modulo 2^CNT_W.
- TRAP:
  - All strobes are 0 and trap=1.
  - TRAP is exited only by reset.
- Reset takes priority over every transition, including mid-wait and TRAP.

Test Plan:
- add x3,x1,x2 (Opcode 0110011, func3 000, func7 0000000) with mem_ready=1: states FETCH, DECODE, EXECR, ALUWB. ALUControl=000 in EXECR, RegWrite=1 in ALUWB, instret 0→1.
- sub (func7 0100000) → ALUControl=001. addi with func7[5]=1 (Opcode[5]=0) → ALUControl=000. func3 110 → 011; func3 111 → 010.
- lw with mem_ready low 3 cycles in MEMREAD: MEMREAD held 4 cycles with AdrSrc=1, then MEMWB with ResultSrc=01 and RegWrite=1. Total 8 cycles; instret=1.
- Branch with Zero=1:
  - func3 000 → PCWrite=1 in BRANCH.
  - func3 001 → PCWrite=0.
  - func3 001 with Zero=0 and BNE_EN=0 → TRAP, trap_cause=01.
- Opcode 1111111 → TRAP after DECODE with trap_cause=01. Holding mem_ready=0 in FETCH with WAIT_LIMIT=15 → TRAP on cycle 17 with cause 10, strobes 0.
- rst=0 asserted mid-MEMWRITE: MemWrite=0 immediately; next edge state=FETCH, instret=0, trap=0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Registered control FSM for a multicycle RV32 core. One shared ALU and one
// unified memory are sequenced over 3-5 cycles per instruction (lw, sw,
// R-type, I-type ALU, beq/bne, jal). Memory states wait on mem_ready with a
// bounded timeout. Illegal opcodes and timeouts fall into a sticky TRAP
// state that only reset leaves. Retired instructions are counted.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-low reset
//   Opcode/func3/func7 instruction fields from the instruction register
//   Zero              ALU zero flag
//   mem_ready         memory completes the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath strobes/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl datapath mux/ALU controls
//   trap, trap_cause  trap indication and reason (01 illegal, 10 timeout)
//   instret           retired-instruction counter, wraps at 2^CNT_W
module multicycle_control_unit #(
   parameter int WAIT_LIMIT = 15,
   parameter int BNE_EN     = 1,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       Opcode,
   input  logic [2:0]       func3,
   input  logic [6:0]       func7,
   input  logic             Zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             AdrSrc,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ImmSrc,
   output logic [2:0]       ALUControl,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] instret
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [7:0] LIMIT         = 8'(WAIT_LIMIT);
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      TRAP     = 4'd11
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [7:0] wait_count;
   logic [1:0] next_cause;
   logic       stall;
   logic       pc_write;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic [2:0] alu_decode;
   logic       bne_legal;
   logic       branch_taken;
   logic       retire;
   logic       unused_func7;

   // Only func7[5] matters for the add/sub split; the rest is folded here.
   assign unused_func7 = ^{func7[6], func7[4:0]};

   assign bne_legal    = (BNE_EN != 0) && (func3 == 3'b001);
   assign branch_taken = ((func3 == 3'b000) && Zero) || (bne_legal && !Zero);

   // Register-register and register-immediate ALU operation select. The
   // sub case needs Opcode[5] so that addi with a stray func7[5] stays add.
   always_comb begin
      alu_decode = 3'b000;
      case (func3)
         3'b000:  alu_decode = (Opcode[5] && func7[5]) ? 3'b001 : 3'b000;
         3'b010:  alu_decode = 3'b101;
         3'b110:  alu_decode = 3'b011;
         3'b111:  alu_decode = 3'b010;
         default: alu_decode = 3'b000;
      endcase
   end

   // Immediate format follows the opcode in every state, so the extender is
   // already settled by the time DECODE needs the branch/jump offset.
   always_comb begin
      ImmSrc = 2'b00;
      case (Opcode)
         OP_SW:   ImmSrc = 2'b01;
         OP_BR:   ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   // Next-state and datapath controls. Strobes are produced raw here and
   // masked by reset below. A stall in a memory wait state that has already
   // used up its budget overrides the normal transition with a timeout trap.
   always_comb begin
      next_state = state;
      next_cause = trap_cause;
      stall      = 1'b0;
      pc_write   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = 3'b000;
      case (state)
         FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            pc_write  = mem_ready;
            ir_write  = mem_ready;
            if (mem_ready) next_state = DECODE;
            else           stall      = 1'b1;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (Opcode)
               OP_LW, OP_SW: next_state = MEMADR;
               OP_R:         next_state = EXECR;
               OP_I:         next_state = EXECI;
               OP_BR:        next_state = BRANCH;
               OP_JAL:       next_state = JAL;
               default: begin
                  next_state = TRAP;
                  next_cause = CAUSE_ILLEGAL;
               end
            endcase
         end
         MEMADR: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            next_state = (Opcode == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            if (mem_ready) next_state = MEMWB;
            else           stall      = 1'b1;
         end
         MEMWB: begin
            ResultSrc  = 2'b01;
            reg_write  = 1'b1;
            next_state = FETCH;
         end
         MEMWRITE: begin
            AdrSrc    = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) next_state = FETCH;
            else           stall      = 1'b1;
         end
         EXECR: begin
            ALUSrcA    = 2'b10;
            ALUControl = alu_decode;
            next_state = ALUWB;
         end
         EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = alu_decode;
            next_state = ALUWB;
         end
         ALUWB: begin
            reg_write  = 1'b1;
            next_state = FETCH;
         end
         BRANCH: begin
            ALUSrcA    = 2'b10;
            ALUControl = 3'b001;
            if ((func3 == 3'b000) || bne_legal) begin
               pc_write   = branch_taken;
               next_state = FETCH;
            end else begin
               next_state = TRAP;
               next_cause = CAUSE_ILLEGAL;
            end
         end
         JAL: begin
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            pc_write   = 1'b1;
            next_state = ALUWB;
         end
         TRAP: begin
            next_state = TRAP;
         end
         default: begin
            next_state = TRAP;
            next_cause = CAUSE_ILLEGAL;
         end
      endcase
      if (stall && (wait_count == LIMIT)) begin
         next_state = TRAP;
         next_cause = CAUSE_TIMEOUT;
      end
   end

   // An instruction retires on the edge that returns to FETCH from one of
   // its final states; jal is counted when it leaves ALUWB.
   assign retire = (next_state == FETCH) &&
                   ((state == MEMWB) || (state == MEMWRITE) ||
                    (state == ALUWB) || (state == BRANCH));

   assign PCWrite  = rst & pc_write;
   assign MemWrite = rst & mem_write;
   assign IRWrite  = rst & ir_write;
   assign RegWrite = rst & reg_write;
   assign trap     = (state == TRAP);

   // State, trap reason, wait counter and retirement counter. The wait
   // counter restarts on every state change so each access gets a fresh
   // budget; it cannot pass LIMIT because reaching it forces a transition.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= FETCH;
         trap_cause <= 2'b00;
         wait_count <= 8'd0;
         instret    <= '0;
      end else begin
         state      <= next_state;
         trap_cause <= next_cause;
         if (next_state != state) wait_count <= 8'd0;
         else if (stall)          wait_count <= wait_count + 8'd1;
         if (retire) instret <= instret + CNT_W'(1);
      end
   end

endmodule
